// File: rtl/chroma_pkg.sv
// Shared constants, line-state enum and saturation helper for the chroma modulator.
package chroma_pkg;

    localparam int unsigned CHROMA_W         = 8;
    localparam int unsigned CNT_W            = 6;

    localparam int unsigned BURST_DELAY_PAL  = 16;
    localparam int unsigned BURST_DELAY_NTSC = 9;
    localparam int unsigned BURST_TICKS_PAL  = 40;
    localparam int unsigned BURST_TICKS_NTSC = 36;
    localparam int unsigned BURST_AMP        = 20;
    localparam int unsigned BURST_AMP_PAL    = 14;

    localparam logic signed [CHROMA_W-1:0] CHROMA_MIN = 8'sh80;
    localparam logic signed [CHROMA_W-1:0] CHROMA_MAX = 8'sh7F;

    typedef enum logic [1:0] {
        ST_SYNC       = 2'd0,
        ST_WAIT_BURST = 2'd1,
        ST_BURST      = 2'd2,
        ST_ACTIVE     = 2'd3
    } line_state_e;

    // Two's-complement negation that maps -128 to +127 instead of wrapping.
    function automatic logic signed [CHROMA_W-1:0] neg_sat(input logic signed [CHROMA_W-1:0] x);
        if (x == CHROMA_MIN) begin
            return CHROMA_MAX;
        end
        return -x;
    endfunction

    // Last counter value spent in WAIT_BURST for the given line standard.
    function automatic logic [CNT_W-1:0] delay_last(input logic ntsc);
        return ntsc ? CNT_W'(BURST_DELAY_NTSC - 1) : CNT_W'(BURST_DELAY_PAL - 1);
    endfunction

    // Last counter value spent in BURST for the given line standard.
    function automatic logic [CNT_W-1:0] burst_last(input logic ntsc);
        return ntsc ? CNT_W'(BURST_TICKS_NTSC - 1) : CNT_W'(BURST_TICKS_PAL - 1);
    endfunction

endpackage

// File: rtl/chroma_line_fsm.sv
// Per-line sequencer: hsync edge detection, burst timing, line standard and PAL V-switch.
module chroma_line_fsm
    import chroma_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode,
    input  logic       hs_sync,
    output logic [1:0] state_nxt_c,
    output logic       line_mode,
    output logic       vswitch
);

    line_state_e      state;
    line_state_e      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hs_smp;
    logic             line_mode_nxt;
    logic             vswitch_nxt;
    logic             hs_fall_c;
    logic             hs_rise_c;

    // Edges of the synchronized hsync, evaluated only on ticks.
    assign hs_fall_c   = tick & hs_smp & ~hs_sync;
    assign hs_rise_c   = tick & ~hs_smp & hs_sync;
    assign state_nxt_c = state_nxt;

    // Next-state logic; hs_fall overrides any terminal count on the same tick.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        line_mode_nxt = line_mode;
        vswitch_nxt   = vswitch;
        if (hs_fall_c) begin
            state_nxt     = ST_SYNC;
            cnt_nxt       = '0;
            line_mode_nxt = mode;
            vswitch_nxt   = mode ? 1'b0 : ~vswitch;
        end else if (tick) begin
            unique case (state)
                ST_SYNC: begin
                    if (hs_rise_c) begin
                        state_nxt = ST_WAIT_BURST;
                        cnt_nxt   = '0;
                    end
                end
                ST_WAIT_BURST: begin
                    if (cnt == delay_last(line_mode)) begin
                        state_nxt = ST_BURST;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (cnt == burst_last(line_mode)) begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    state_nxt = ST_ACTIVE;
                end
                default: begin
                    state_nxt = ST_SYNC;
                end
            endcase
        end
    end

    // State, counter, line standard and V-switch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SYNC;
            cnt       <= '0;
            line_mode <= 1'b0;
            vswitch   <= 1'b0;
            hs_smp    <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            line_mode <= line_mode_nxt;
            vswitch   <= vswitch_nxt;
            if (tick) begin
                hs_smp <= hs_sync;
            end
        end
    end

endmodule

// File: rtl/chroma_modulator.sv
// Quadrature chroma modulator: subcarrier tick, phase counter, sync inputs and output mux.
module chroma_modulator
    import chroma_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clkcolor4x,
    input  logic       mode,
    input  logic       hsync_n,
    input  logic       blank_n,
    input  logic [7:0] u_in,
    input  logic [7:0] v_in,
    output logic [7:0] chroma,
    output logic       burst_on,
    output logic       vswitch
);

    localparam logic signed [CHROMA_W-1:0] AMP_NTSC = CHROMA_W'(BURST_AMP);
    localparam logic signed [CHROMA_W-1:0] AMP_PAL  = CHROMA_W'(BURST_AMP_PAL);

    logic                       cc_dly;
    logic                       tick_c;
    logic                       hs_s1;
    logic                       hs_s2;
    logic                       bl_s1;
    logic                       bl_s2;
    logic [1:0]                 phase;
    logic [1:0]                 st_nxt_raw;
    line_state_e                st_nxt;
    logic                       line_mode;
    logic                       out_en;
    logic signed [CHROMA_W-1:0] u_sel;
    logic signed [CHROMA_W-1:0] v_sel;
    logic signed [CHROMA_W-1:0] chroma_d;

    assign tick_c = clkcolor4x & ~cc_dly;
    assign st_nxt = line_state_e'(st_nxt_raw);

    // Subcarrier delay for tick detection plus 2-flop synchronizers for hsync/blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_dly <= 1'b0;
            hs_s1  <= 1'b1;
            hs_s2  <= 1'b1;
            bl_s1  <= 1'b1;
            bl_s2  <= 1'b1;
        end else begin
            cc_dly <= clkcolor4x;
            hs_s1  <= hsync_n;
            hs_s2  <= hs_s1;
            bl_s1  <= blank_n;
            bl_s2  <= bl_s1;
        end
    end

    chroma_line_fsm u_line_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick_c),
        .mode        (mode),
        .hs_sync     (hs_s2),
        .state_nxt_c (st_nxt_raw),
        .line_mode   (line_mode),
        .vswitch     (vswitch)
    );

    // Pick (U,V) for the state being entered and rotate through the quadrature phases.
    always_comb begin
        out_en   = 1'b0;
        u_sel    = '0;
        v_sel    = '0;
        chroma_d = '0;
        unique case (st_nxt)
            ST_BURST: begin
                out_en = 1'b1;
                if (line_mode) begin
                    u_sel = neg_sat(AMP_NTSC);
                    v_sel = '0;
                end else begin
                    u_sel = neg_sat(AMP_PAL);
                    v_sel = vswitch ? neg_sat(AMP_PAL) : AMP_PAL;
                end
            end
            ST_ACTIVE: begin
                out_en = bl_s2;
                u_sel  = u_in;
                v_sel  = (vswitch & ~line_mode) ? neg_sat(v_in) : v_in;
            end
            default: begin
                out_en = 1'b0;
            end
        endcase
        unique case (phase)
            2'd0:    chroma_d = u_sel;
            2'd1:    chroma_d = v_sel;
            2'd2:    chroma_d = neg_sat(u_sel);
            default: chroma_d = neg_sat(v_sel);
        endcase
        if (!out_en) begin
            chroma_d = '0;
        end
    end

    // Phase counter and output registers advance together on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 2'd0;
            chroma   <= '0;
            burst_on <= 1'b0;
        end else if (tick_c) begin
            phase    <= phase + 2'd1;
            chroma   <= chroma_d;
            burst_on <= (st_nxt == ST_BURST);
        end
    end

endmodule

// File: tb/tb_chroma_modulator.sv
// Self-checking bench for chroma_modulator: per-tick line model, vector table, corner sequences.
module tb_chroma_modulator;

    logic       clk;
    logic       rst_n;
    logic       clkcolor4x;
    logic       mode;
    logic       hsync_n;
    logic       blank_n;
    logic [7:0] u_in;
    logic [7:0] v_in;
    logic [7:0] chroma;
    logic       burst_on;
    logic       vswitch;

    int checks   = 0;
    int failures = 0;
    int n_ticks  = 0;

    // model state: position in the line counted in ticks since hsync rose
    int m_tick_idx;
    bit m_in_sync;
    int m_pos;
    bit m_prev_hs;
    bit m_vsw;
    bit m_lm;
    bit cc_prev;

    int lb_first;
    int lb_len;
    int lb_c [4];

    typedef struct {
        logic signed [7:0] u;
        logic signed [7:0] v;
        bit                blank;
        int                e0, e1, e2, e3;
    } vec_t;
    vec_t vecs [6];

    chroma_modulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clkcolor4x (clkcolor4x),
        .mode       (mode),
        .hsync_n    (hsync_n),
        .blank_n    (blank_n),
        .u_in       (u_in),
        .v_in       (v_in),
        .chroma     (chroma),
        .burst_on   (burst_on),
        .vswitch    (vswitch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 4x subcarrier: one rising edge every 8 clk cycles
    initial begin
        int cc_cnt;
        cc_cnt = 0;
        clkcolor4x = 1'b0;
        forever begin
            @(negedge clk);
            cc_cnt = (cc_cnt + 1) % 8;
            clkcolor4x = (cc_cnt < 4);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int clamp8(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic void model_reset();
        m_tick_idx = 0;
        m_in_sync  = 1'b1;
        m_pos      = 0;
        m_prev_hs  = 1'b1;
        m_vsw      = 1'b0;
        m_lm       = 1'b0;
    endfunction

    // reference model: evaluated on every tick, compared 1 ns after the tick edge
    initial begin
        bit tk, hs, bl, md, fall, rise;
        int uu, vv, eu, ev, val, ph, d, b, region, exp_c, exp_b;
        cc_prev = 1'b0;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                cc_prev = 1'b0;
            end else begin
                tk = clkcolor4x && !cc_prev;
                cc_prev = clkcolor4x;
                if (tk) begin
                    hs = hsync_n; bl = blank_n; md = mode;
                    uu = int'($signed(u_in));
                    vv = int'($signed(v_in));
                    fall = m_prev_hs && !hs;
                    rise = !m_prev_hs && hs;
                    m_prev_hs = hs;
                    ph = m_tick_idx % 4;
                    m_tick_idx++;
                    if (fall) begin
                        m_lm = md;
                        m_vsw = md ? 1'b0 : !m_vsw;
                        m_in_sync = 1'b1;
                    end else if (m_in_sync && rise) begin
                        m_in_sync = 1'b0;
                        m_pos = 0;
                    end else if (!m_in_sync) begin
                        m_pos++;
                    end
                    d = m_lm ? 9 : 16;
                    b = m_lm ? 36 : 40;
                    if (m_in_sync || m_pos < d) region = 0;
                    else if (m_pos < d + b)     region = 1;
                    else                        region = 2;
                    if (region == 1) begin
                        eu = m_lm ? -20 : -14;
                        ev = m_lm ? 0 : (m_vsw ? -14 : 14);
                    end else begin
                        eu = uu;
                        ev = (m_vsw && !m_lm) ? clamp8(-vv) : vv;
                    end
                    case (ph)
                        0: val = eu;
                        1: val = ev;
                        2: val = -eu;
                        default: val = -ev;
                    endcase
                    val = clamp8(val);
                    exp_c = (region == 1 || (region == 2 && bl)) ? val : 0;
                    exp_b = (region == 1) ? 1 : 0;
                    #1;
                    chk("model_chroma", int'($signed(chroma)), exp_c);
                    chk("model_burst_on", int'(burst_on), exp_b);
                    chk("model_vswitch", int'(vswitch), int'(m_vsw));
                    n_ticks++;
                end
            end
        end
    end

    task automatic wait_tick();
        int start;
        int guard;
        start = n_ticks;
        guard = 0;
        while (n_ticks == start && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (n_ticks == start) begin
            failures++;
            $display("FAIL wait_tick: got no tick expected a tick within 40 clk");
        end
    endtask

    task automatic run_line(input bit md, input int sync_t, input int act_t,
                            input bit rnd, input int flip_at);
        int ph;
        lb_first = -1;
        lb_len   = 0;
        for (int i = 0; i < 4; i++) lb_c[i] = 999;
        mode    = md;
        hsync_n = 1'b0;
        repeat (sync_t) wait_tick();
        hsync_n = 1'b1;
        wait_tick();
        for (int k = 1; k <= act_t; k++) begin
            if (k == flip_at) mode = ~mode;
            if (rnd) begin
                u_in    = 8'($urandom);
                v_in    = 8'($urandom);
                blank_n = ($urandom_range(0, 3) != 0);
            end
            wait_tick();
            if (burst_on) begin
                if (lb_first < 0) lb_first = k;
                lb_len++;
                ph = (m_tick_idx + 3) % 4;
                lb_c[ph] = int'($signed(chroma));
            end
        end
    endtask

    initial begin
        int seen;
        int got;
        int exp;
        bit md;

        vecs[0] = '{8'sd30,   -8'sd10,  1'b1,   30,   10,  -30,  -10};
        vecs[1] = '{-8'sd128, 8'sd5,    1'b1, -128,   -5,  127,    5};
        vecs[2] = '{8'sd127,  8'sh80,   1'b1,  127,  127, -127, -127};
        vecs[3] = '{-8'sd1,   8'sd1,    1'b1,   -1,   -1,    1,    1};
        vecs[4] = '{8'sd50,   8'sd50,   1'b0,    0,    0,    0,    0};
        vecs[5] = '{8'sd0,    8'sd0,    1'b1,    0,    0,    0,    0};

        rst_n = 1'b0; mode = 1'b0; hsync_n = 1'b1; blank_n = 1'b0;
        u_in = '0; v_in = '0;
        repeat (5) @(negedge clk);
        chk("reset_chroma", int'(chroma), 0);
        chk("reset_burst_on", int'(burst_on), 0);
        chk("reset_vswitch", int'(vswitch), 0);
        rst_n = 1'b1;

        // no hsync activity after reset: must stay silent
        seen = 0;
        repeat (70) begin wait_tick(); if (burst_on) seen++; end
        chk("idle_after_reset_burst", seen, 0);

        // first PAL line after reset: vswitch=1, run the vector table in ACTIVE
        mode = 1'b0; blank_n = 1'b1; hsync_n = 1'b0;
        repeat (3) wait_tick();
        hsync_n = 1'b1;
        wait_tick();
        repeat (60) wait_tick();
        chk("table_line_vswitch", int'(vswitch), 1);
        for (int i = 0; i < 6; i++) begin
            while (m_tick_idx % 4 != 0) wait_tick();
            u_in = vecs[i].u; v_in = vecs[i].v; blank_n = vecs[i].blank;
            for (int p = 0; p < 4; p++) begin
                wait_tick();
                case (p)
                    0: exp = vecs[i].e0;
                    1: exp = vecs[i].e1;
                    2: exp = vecs[i].e2;
                    default: exp = vecs[i].e3;
                endcase
                got = int'($signed(chroma));
                chk($sformatf("table_vec%0d_ph%0d", i, p), got, exp);
            end
        end

        // two more PAL lines: vswitch alternates, burst V flips sign
        run_line(1'b0, 3, 62, 1'b0, -1);
        chk("pal2_vswitch", int'(vswitch), 0);
        chk("pal2_burst_first", lb_first, 16);
        chk("pal2_burst_len", lb_len, 40);
        chk("pal2_burst_u", lb_c[0], -14);
        chk("pal2_burst_v", lb_c[1], 14);
        run_line(1'b0, 3, 62, 1'b0, -1);
        chk("pal3_vswitch", int'(vswitch), 1);
        chk("pal3_burst_len", lb_len, 40);
        chk("pal3_burst_v", lb_c[1], -14);
        chk("pal3_burst_nv", lb_c[3], 14);

        // NTSC line: burst 9 ticks after rise, 36 long, -20,0,+20,0
        run_line(1'b1, 2, 50, 1'b0, -1);
        chk("ntsc_vswitch", int'(vswitch), 0);
        chk("ntsc_burst_first", lb_first, 9);
        chk("ntsc_burst_len", lb_len, 36);
        chk("ntsc_burst_ph0", lb_c[0], -20);
        chk("ntsc_burst_ph1", lb_c[1], 0);
        chk("ntsc_burst_ph2", lb_c[2], 20);
        chk("ntsc_burst_ph3", lb_c[3], 0);

        // mode flipped during WAIT_BURST of a PAL line: only the next line is NTSC
        run_line(1'b0, 2, 62, 1'b0, 5);
        chk("flip_same_line_first", lb_first, 16);
        chk("flip_same_line_len", lb_len, 40);
        run_line(1'b1, 2, 50, 1'b0, -1);
        chk("flip_next_line_first", lb_first, 9);
        chk("flip_next_line_len", lb_len, 36);

        // hs_fall landing on the 5th burst tick aborts the burst immediately
        mode = 1'b0; hsync_n = 1'b0;
        repeat (2) wait_tick();
        hsync_n = 1'b1;
        wait_tick();
        repeat (19) wait_tick();
        chk("abort_pre_burst_on", int'(burst_on), 1);
        hsync_n = 1'b0;
        wait_tick();
        chk("abort_chroma", int'(chroma), 0);
        chk("abort_burst_on", int'(burst_on), 0);
        seen = 0;
        repeat (3) begin wait_tick(); if (burst_on || chroma != 8'd0) seen++; end
        chk("abort_stays_sync", seen, 0);
        hsync_n = 1'b1;
        wait_tick();

        // randomized lines
        for (int n = 0; n < 8; n++) begin
            md = 1'($urandom_range(0, 1));
            run_line(md, $urandom_range(2, 5), $urandom_range(60, 80), 1'b1, -1);
            chk($sformatf("rand%0d_burst_first", n), lb_first, md ? 9 : 16);
            chk($sformatf("rand%0d_burst_len", n), lb_len, md ? 36 : 40);
        end

        // asynchronous reset in the middle of ACTIVE
        blank_n = 1'b1; u_in = 8'd40; v_in = 8'd40;
        run_line(1'b0, 2, 60, 1'b0, -1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_chroma", int'(chroma), 0);
        chk("async_rst_burst_on", int'(burst_on), 0);
        chk("async_rst_vswitch", int'(vswitch), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin wait_tick(); if (burst_on) seen++; end
        chk("midline_release_no_burst", seen, 0);
        run_line(1'b0, 3, 62, 1'b0, -1);
        chk("post_rst_burst_first", lb_first, 16);
        chk("post_rst_burst_len", lb_len, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chroma_modulator.md
CHROMA_MODULATOR -- requirements
Module: chroma_modulator

Interface
REQ-001 Parameters SHALL be none; all timing and amplitude constants come from the shared package.
REQ-002 clk  input  1  fast system clock, 140 or 165 MHz; the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clkcolor4x  input  1  4x-subcarrier square wave (17.734475 MHz PAL / 14.31818 MHz NTSC), generated in the clk domain.
REQ-005 mode  input  1  0=PAL, 1=NTSC.
REQ-006 hsync_n  input  1  horizontal sync, active low, asynchronous to clk.
REQ-007 blank_n  input  1  active-video qualifier, high during visible pixels.
REQ-008 u_in  input  8  signed U colour-difference sample.
REQ-009 v_in  input  8  signed V colour-difference sample.
REQ-010 chroma  output  8  signed modulated chroma, registered.
REQ-011 burst_on  output  1  high while chroma carries colour burst.
REQ-012 vswitch  output  1  current PAL V-switch state, forced 0 in NTSC.

Function
REQ-013 Tick SHALL be a 1-clk pulse, asserted when clkcolor4x=1 and its clk-delayed copy=0.
- No synchronizer on clkcolor4x; it is already clk-domain.
REQ-014 hsync_n and blank_n SHALL pass through 2-flop synchronizers before use.
REQ-015 A 2-bit phase counter SHALL increment modulo 4 on every tick.
REQ-016 All state, counter, sampling and output updates SHALL occur only on ticks.
- Output register changes on the clk edge ending the tick cycle: latency 1 clk from tick.
REQ-017 The synchronized hsync SHALL be resampled every tick; falling edge = hs_fall, rising edge = hs_rise.
REQ-018 FSM states: SYNC, WAIT_BURST, BURST, ACTIVE.
REQ-019 hs_fall from any state SHALL go to SYNC.
- On hs_fall: latch mode into line_mode and toggle vswitch when line_mode(new)=0.
REQ-020 SYNC -> WAIT_BURST on hs_rise; counter cleared.
REQ-021 WAIT_BURST -> BURST after BURST_DELAY ticks: 16 PAL / 9 NTSC.
REQ-022 BURST -> ACTIVE after BURST_TICKS ticks: 40 PAL / 36 NTSC.
REQ-023 ACTIVE SHALL persist until hs_fall.
REQ-024 hs_fall and a counter terminal count on the same tick SHALL resolve to SYNC (hs_fall wins).
REQ-025 Effective V in ACTIVE SHALL be V' = -v_in when vswitch=1 and line_mode=0, else v_in.
REQ-026 ACTIVE with blank_n=1: chroma by phase SHALL be 0:+u_in, 1:+V', 2:-u_in, 3:-V'.
REQ-027 Negation SHALL saturate: -(-128) = +127.
REQ-028 SYNC, WAIT_BURST, and ACTIVE with blank_n=0 SHALL output chroma = 0.
REQ-029 Burst SHALL use the REQ-026 phase map with fixed (U,V) values.
- NTSC: (U,V) = (-BURST_AMP, 0), BURST_AMP = 20.
- PAL: (U,V) = (-BURST_AMP_PAL, vswitch ? -BURST_AMP_PAL : +BURST_AMP_PAL), BURST_AMP_PAL = 14.
REQ-030 burst_on SHALL be 1 exactly while state=BURST, registered alongside chroma.
REQ-031 A mode change mid-line SHALL take effect only at the next hs_fall; line_mode holds until then.
REQ-032 vswitch SHALL be forced 0 when line_mode=1.

Reset
REQ-033 rst_n low SHALL asynchronously set: state=SYNC, phase=0, counter=0, vswitch=0, line_mode=0, chroma=0, burst_on=0, synchronizer and edge-history flops=1 (idle hsync) / 0 (clkcolor4x delay).
REQ-034 Reset released mid-line SHALL wait in SYNC for a full hs_fall/hs_rise pair before any burst.

Structure
REQ-035 Package chroma_pkg SHALL hold the state enum, BURST_DELAY_PAL/NTSC, BURST_TICKS_PAL/NTSC, BURST_AMP and BURST_AMP_PAL.
REQ-036 One sub-module chroma_line_fsm SHALL contain the FSM, tick counter, line_mode and vswitch; the top holds tick detection, phase counter, synchronizers and the output mux/saturation.

Verification
REQ-037 NTSC, hsync pulse then wait: exactly 9 ticks after hs_rise burst_on=1 for 36 ticks; chroma sequence -20,0,+20,0 repeating.
REQ-038 PAL, two consecutive lines: vswitch toggles; burst V component = +14 then -14; burst lasts 40 ticks.
REQ-039 ACTIVE, blank_n=1, u_in=30, v_in=-10, PAL vswitch=1: chroma = 30,10,-30,-10 per consecutive ticks.
REQ-040 u_in=-128 at phase 2: chroma=+127.
REQ-041 hs_fall injected during BURST at tick 5: next output chroma=0, burst_on=0, state SYNC.
REQ-042 rst_n asserted mid-ACTIVE, asynchronous to clk: chroma=0 and burst_on=0 immediately; mode flipped mid-line changes burst length only from the following line.
